ahb_lite_interconnect: RTL and testbench

Parametrised single-master, N-slave AHB-Lite interconnect; successor to the fixed point-to-point master/slave top.
- Decodes the address phase into one-hot slave selects.
- Tracks the data phase with a registered select and muxes the selected slave's read data, ready and response back to the master.
- Unmapped accesses go to an internal default slave, which returns the two-cycle AHB ERROR response and counts the errors.

---
 rtl/ahb_pkg.sv | 31 +++
 rtl/ahb_lite_interconnect_if.sv | 33 +++
 rtl/ahb_default_slave.sv | 55 +++++
 rtl/ahb_lite_interconnect.sv | 92 +++++++++
 tb/tb_ahb_lite_interconnect.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the interconnect slice.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } def_state_e;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned r;
        v = 1;
        r = 0;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_lite_interconnect_if.sv
// Bus bundle between one AHB-Lite master, the interconnect and N slaves.
interface ahb_lite_interconnect_if #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]            HADDR;
    logic [1:0]                       HTRANS;
    logic                             HWRITE;
    logic [2:0]                       HSIZE;
    logic [DATA_WIDTH-1:0]            HRDATA;
    logic                             HREADY;
    logic [1:0]                       HRESP;
    logic [NUM_SLAVES-1:0]            s_HSEL;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_HRDATA;
    logic [NUM_SLAVES-1:0]            s_HREADYOUT;
    logic [NUM_SLAVES*2-1:0]          s_HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HREADY, s_HSEL,
        output s_HRDATA, s_HREADYOUT, s_HRESP
    );

    modport fabric (
        input  HADDR, HTRANS, HWRITE, HSIZE, s_HRDATA, s_HREADYOUT, s_HRESP,
        output HRDATA, HREADY, HRESP, s_HSEL
    );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response plus a
// saturating count of the active transfers it has rejected.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HREADY,
    input  logic [1:0]           HTRANS,
    input  logic                 sel,
    output logic                 readyout,
    output logic [1:0]           resp,
    output logic [CNT_WIDTH-1:0] err_count
);

    def_state_e state, state_nxt;
    logic       readyout_nxt;
    logic [1:0] resp_nxt;
    logic       err_hit;
    logic       unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Next state, with outputs decoded from the next state so they register cleanly.
    always_comb begin
        state_nxt = state;
        err_hit   = HTRANS[1] && sel;
        case (state)
            DS_IDLE: if (HREADY && err_hit) state_nxt = DS_ERR1;
            DS_ERR1: state_nxt = DS_ERR2;
            DS_ERR2: state_nxt = err_hit ? DS_ERR1 : DS_IDLE;
            default: state_nxt = DS_IDLE;
        endcase
        readyout_nxt = (state_nxt != DS_ERR1);
        resp_nxt     = (state_nxt == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= DS_IDLE;
            readyout  <= 1'b1;
            resp      <= HRESP_OKAY;
            err_count <= '0;
        end else begin
            state    <= state_nxt;
            readyout <= readyout_nxt;
            resp     <= resp_nxt;
            if (state_nxt == DS_ERR1 && err_count != '1)
                err_count <= err_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master, N-slave AHB-Lite interconnect: address decode, registered
// data-phase select, response mux and an internal default slave.
module ahb_lite_interconnect
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REGION_LSB = 12,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    ahb_lite_interconnect_if.fabric       bus,
    output logic [CNT_WIDTH-1:0]          err_count
);

    localparam int unsigned SEL_W = clog2(NUM_SLAVES);
    localparam int unsigned IDX_W = (SEL_W == 0) ? 1 : SEL_W;

    logic [IDX_W-1:0]      idx;
    logic                  upper_zero;
    logic                  mapped;
    logic [NUM_SLAVES-1:0] hsel_c;
    logic [IDX_W-1:0]      dsel_idx;
    logic                  dsel_def;
    logic                  def_readyout;
    logic [1:0]            def_resp;
    logic [DATA_WIDTH-1:0] hrdata_c;
    logic                  hready_c;
    logic [1:0]            hresp_c;
    logic                  unused_ctrl;

    assign unused_ctrl = ^{bus.HWRITE, bus.HSIZE, bus.HTRANS[0]};

    // Address decode; slaves qualify the select with HTRANS and HREADY themselves.
    assign upper_zero = ((bus.HADDR >> (REGION_LSB + SEL_W)) == '0);
    assign idx        = IDX_W'(bus.HADDR >> REGION_LSB);
    assign mapped     = upper_zero && (32'(idx) < NUM_SLAVES);

    always_comb begin
        hsel_c = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            hsel_c[i] = mapped && (idx == IDX_W'(i));
    end

    assign bus.s_HSEL = hsel_c;

    // Data-phase owner advances only when the current data phase completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_def <= 1'b1;
            dsel_idx <= '0;
        end else if (hready_c) begin
            dsel_def <= !mapped;
            dsel_idx <= idx;
        end
    end

    always_comb begin
        hrdata_c = '0;
        hready_c = def_readyout;
        hresp_c  = def_resp;
        if (!dsel_def) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_idx == IDX_W'(i)) begin
                    hrdata_c = bus.s_HRDATA[i*DATA_WIDTH +: DATA_WIDTH];
                    hready_c = bus.s_HREADYOUT[i];
                    hresp_c  = bus.s_HRESP[i*2 +: 2];
                end
            end
        end
    end

    assign bus.HRDATA = hrdata_c;
    assign bus.HREADY = hready_c;
    assign bus.HRESP  = hresp_c;

    ahb_default_slave #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HREADY    (hready_c),
        .HTRANS    (bus.HTRANS),
        .sel       (!mapped),
        .readyout  (def_readyout),
        .resp      (def_resp),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Self-checking bench: directed protocol scenarios plus randomized traffic
// compared every cycle against a transfer-level model of the interconnect.
module tb_ahb_lite_interconnect;
    import ahb_pkg::*;

    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LSB = 12;
    localparam int CW  = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] err_count;

    ahb_lite_interconnect_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ahb_lite_interconnect #(
        .NUM_SLAVES (NS),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .REGION_LSB (LSB),
        .CNT_WIDTH  (CW)
    ) dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Transfer-level model: who owns the data phase and how far an error reply has gone.
    int m_def;   // 1 when the data phase belongs to the default slave
    int m_idx;   // owning slave otherwise
    int m_left;  // remaining ERROR cycles of the default slave's current reply
    int m_cnt;

    localparam logic [NS*DW-1:0] D_BASE = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_mapped(input logic [31:0] a);
        return (a >> (LSB + 2)) == 0;
    endfunction

    function automatic int addr_slave(input logic [31:0] a);
        return int'((a >> LSB) % NS);
    endfunction

    function automatic logic exp_ready();
        if (m_def != 0) return (m_left == 2) ? 1'b0 : 1'b1;
        return bus.s_HREADYOUT[m_idx];
    endfunction

    task automatic model_reset();
        m_def  = 1;
        m_idx  = 0;
        m_left = 0;
        m_cnt  = 0;
    endtask

    task automatic model_check();
        logic [NS-1:0] e_sel;
        logic [DW-1:0] e_data;
        logic [1:0]    e_resp;
        e_sel = '0;
        if (addr_mapped(bus.HADDR)) e_sel = NS'(1 << addr_slave(bus.HADDR));
        if (m_def != 0) begin
            e_data = '0;
            e_resp = (m_left > 0) ? HRESP_ERROR : HRESP_OKAY;
        end else begin
            e_data = bus.s_HRDATA[m_idx*DW +: DW];
            e_resp = bus.s_HRESP[m_idx*2 +: 2];
        end
        chk("s_HSEL", 64'(bus.s_HSEL), 64'(e_sel));
        chk("HREADY", 64'(bus.HREADY), 64'(exp_ready()));
        chk("HRESP", 64'(bus.HRESP), 64'(e_resp));
        chk("HRDATA", 64'(bus.HRDATA), 64'(e_data));
        chk("err_count", 64'(err_count), 64'(m_cnt));
    endtask

    task automatic model_step();
        if (exp_ready()) begin
            if (addr_mapped(bus.HADDR)) begin
                m_def  = 0;
                m_idx  = addr_slave(bus.HADDR);
                m_left = 0;
            end else begin
                m_def  = 1;
                m_left = bus.HTRANS[1] ? 2 : 0;
                if (bus.HTRANS[1] && m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (m_def != 0 && m_left == 2) begin
            m_left = 1;
        end
    endtask

    task automatic apply(input logic [31:0] addr, input logic [1:0] trans,
                         input logic [NS-1:0] rdy, input logic [NS*DW-1:0] d,
                         input logic [2*NS-1:0] rs);
        bus.HADDR       = addr;
        bus.HTRANS      = trans;
        bus.HWRITE      = 1'b0;
        bus.HSIZE       = 3'b010;
        bus.s_HREADYOUT = rdy;
        bus.s_HRDATA    = d;
        bus.s_HRESP     = rs;
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    // Async reset pulse between the checking edge and the next rising edge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_HREADY", 64'(bus.HREADY), 64'd1);
        chk("rst_HRESP", 64'(bus.HRESP), 64'd0);
        chk("rst_HRDATA", 64'(bus.HRDATA), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [NS*DW-1:0] dv;
        logic [31:0]      a;
        logic [NS-1:0]    r;
        int               sat_exp [5];
        sat_exp = '{1, 2, 3, 3, 3};
        model_reset();

        // Reset state
        apply(32'hFFFF_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        chk("reset_hsel", 64'(bus.s_HSEL), 64'd0);
        chk("reset_hready", 64'(bus.HREADY), 64'd1);
        chk("reset_err", 64'(err_count), 64'd0);
        #2 rst_n = 1'b1;
        advance();

        // Mapped zero-wait write to slave 2
        apply(32'h0000_2004, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
        chk("wr_hsel", 64'(bus.s_HSEL), 64'b0100);
        advance();
        apply(32'h0000_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        chk("wr_hready", 64'(bus.HREADY), 64'd1);
        chk("wr_hresp", 64'(bus.HRESP), 64'd0);
        advance();

        // Mapped read with two wait states from slave 1
        apply(32'h0000_1000, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(32'h0000_0000, HTRANS_IDLE, 4'b1101, D_BASE, 8'h00);
            chk("rd_wait", 64'(bus.HREADY), 64'd0);
            advance();
        end
        dv = D_BASE;
        dv[DW +: DW] = 32'hDEAD_BEEF;
        apply(32'h0000_0000, HTRANS_IDLE, 4'hF, dv, 8'h00);
        chk("rd_hready", 64'(bus.HREADY), 64'd1);
        chk("rd_data", 64'(bus.HRDATA), 64'hDEAD_BEEF);
        advance();

        // Unmapped NONSEQ, then IDLE to the same address
        apply(32'h0001_0000, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
        chk("unm_hsel", 64'(bus.s_HSEL), 64'd0);
        advance();
        apply(32'h0001_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        chk("err1_ready", 64'(bus.HREADY), 64'd0);
        chk("err1_resp", 64'(bus.HRESP), 64'd1);
        advance();
        apply(32'h0001_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        chk("err2_ready", 64'(bus.HREADY), 64'd1);
        chk("err2_resp", 64'(bus.HRESP), 64'd1);
        advance();
        apply(32'h0001_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        chk("post_err_resp", 64'(bus.HRESP), 64'd0);
        chk("unm_count", 64'(err_count), 64'd1);
        advance();
        apply(32'h0000_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        chk("idle_unm_ready", 64'(bus.HREADY), 64'd1);
        chk("idle_unm_count", 64'(err_count), 64'd1);
        advance();

        // Pipelined: slave 0, unmapped, slave 3
        apply(32'h0000_0000, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
        advance();
        apply(32'h0001_0000, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
        advance();
        apply(32'h0000_3000, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
        chk("pipe_err1", 64'(bus.HREADY), 64'd0);
        chk("pipe_hsel", 64'(bus.s_HSEL), 64'b1000);
        advance();
        apply(32'h0000_3000, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
        chk("pipe_err2", 64'({bus.HREADY, bus.HRESP}), 64'b101);
        advance();
        apply(32'h0000_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'hC0);
        chk("pipe_s3_data", 64'(bus.HRDATA), 64'h3333_3333);
        chk("pipe_s3_resp", 64'(bus.HRESP), 64'd3);
        chk("pipe_count", 64'(err_count), 64'd2);
        advance();

        // Reset asserted during ERR1
        apply(32'h0001_0000, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
        advance();
        apply(32'h0000_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        chk("mid_err1", 64'(bus.HREADY), 64'd0);
        pulse_reset();
        advance();
        apply(32'h0000_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        chk("after_rst", 64'({bus.HREADY, bus.HRESP}), 64'b100);
        advance();

        // Saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            apply(32'h0002_0000, HTRANS_NONSEQ, 4'hF, D_BASE, 8'h00);
            advance();
            apply(32'h0002_0000, HTRANS_SEQ, 4'hF, D_BASE, 8'h00);
            chk("sat_count", 64'(err_count), 64'(sat_exp[k]));
            advance();
        end
        apply(32'h0000_0000, HTRANS_IDLE, 4'hF, D_BASE, 8'h00);
        advance();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            int sel_kind;
            sel_kind = $urandom_range(0, 9);
            if (sel_kind <= 5)
                a = (32'($urandom_range(0, NS - 1)) << LSB) | ($urandom & 32'hFFF);
            else if (sel_kind <= 7)
                a = (32'($urandom_range(1, 32'h3FFFF)) << (LSB + 2)) | ($urandom & 32'h3FFF);
            else
                a = $urandom;
            for (int s = 0; s < NS; s++) begin
                r[s] = ($urandom_range(0, 3) != 0);
                dv[s*DW +: DW] = $urandom;
            end
            apply(a, 2'($urandom), r, dv, 8'($urandom));
            if ($urandom_range(0, 199) == 0) pulse_reset();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
